// File: rtl/pwm_pkg.sv
// Shared types for the PWM duty sequencer: controller state encoding and duty word.
package pwm_pkg;

    // Default duty width; instances may override DUTY_W on the controller.
    localparam int unsigned DutyWDefault = 8;

    typedef logic [DutyWDefault-1:0] duty_t;

    // Encoding is visible on state_o, so values are pinned explicitly.
    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StStop  = 2'd3
    } pwm_ctrl_state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational single-channel ramp step: moves cur toward eff by at most STEP,
// landing exactly on eff instead of overshooting.
module pwm_ramp_step
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned STEP   = 1
) (
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] eff,
    output logic [DUTY_W-1:0] nxt
);

    localparam logic [DUTY_W:0]   StepWide = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] StepNarrow = DUTY_W'(STEP);

    // One extra bit so the distance never wraps.
    logic [DUTY_W:0] dist_up;
    logic [DUTY_W:0] dist_dn;

    assign dist_up = {1'b0, eff} - {1'b0, cur};
    assign dist_dn = {1'b0, cur} - {1'b0, eff};

    // Step toward eff; a full STEP is only taken when it stays short of eff.
    always_comb begin
        nxt = cur;
        if (cur < eff) begin
            nxt = (dist_up > StepWide) ? cur + StepNarrow : eff;
        end else if (cur > eff) begin
            nxt = (dist_dn > StepWide) ? cur - StepNarrow : eff;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel PWM duty sequencer with soft-start/soft-stop.
// Build option: define PWM_RAMP_EN for stepped ramping (STEP per RAMP_DIV periods);
// without it every period_end applies the effective target directly.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned STEP     = 1,
    parameter int unsigned RAMP_DIV = 4,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     period_end,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [DUTY_W-1:0]        wr_duty,
    output logic [N_CH*DUTY_W-1:0]   duty_o,
    output logic                     pwm_en,
    output logic                     busy,
    output logic [1:0]               state_o
);

    logic [DUTY_W-1:0] tgt_q [N_CH];
    logic [DUTY_W-1:0] cur_q [N_CH];
    logic [DUTY_W-1:0] cur_d [N_CH];
    logic [DUTY_W-1:0] eff   [N_CH];

    pwm_ctrl_state_e state_q;
    logic            pwm_en_q;
    logic            busy_q;
    logic            wr_ready_q;
    logic            tick;
    logic            eff_on;
    logic            all_eq;
    logic            all_zero;

    assign eff_on = (state_q == StStart) || (state_q == StRun);

    // Effective target follows the host target only while powering up or running.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            eff[i] = eff_on ? tgt_q[i] : '0;
        end
    end

    // Completion flags are taken from the registered duties.
    always_comb begin
        all_eq   = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_q[i] != eff[i]) all_eq = 1'b0;
            if (cur_q[i] != '0)     all_zero = 1'b0;
        end
    end

    // Host target registers; out-of-range channel indices match no register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) tgt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_valid && wr_ready_q && (wr_ch == CH_W'(i))) tgt_q[i] <= wr_duty;
            end
        end
    end

`ifdef PWM_RAMP_EN
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DivLast = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0] div_q;

    assign tick = period_end && (div_q == DivLast);

    // Period prescaler; parked at 0 while off so each start begins a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (state_q == StOff) begin
            div_q <= '0;
        end else if (period_end) begin
            div_q <= (div_q == DivLast) ? '0 : div_q + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_step
        pwm_ramp_step #(
            .DUTY_W (DUTY_W),
            .STEP   (STEP)
        ) u_step (
            .cur (cur_q[g]),
            .eff (eff[g]),
            .nxt (cur_d[g])
        );
    end
`else
    // Without ramping every period boundary jumps straight to the effective target.
    assign tick = period_end;

    for (genvar g = 0; g < N_CH; g++) begin : g_direct
        assign cur_d[g] = eff[g];
    end

    logic [31:0] unused_cfg;
    assign unused_cfg = STEP ^ RAMP_DIV;
`endif

    // Applied duties only change on a tick, i.e. on a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) cur_q[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < N_CH; i++) cur_q[i] <= cur_d[i];
        end
    end

    // Sequencing FSM plus its registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOff;
            pwm_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            wr_ready_q <= 1'b1;
            pwm_en_q   <= (state_q != StOff);
            busy_q     <= !all_eq;
            case (state_q)
                StOff: begin
                    if (en) state_q <= StStart;
                end
                StStart: begin
                    if (!en)        state_q <= StStop;
                    else if (all_eq) state_q <= StRun;
                end
                StRun: begin
                    if (!en) state_q <= StStop;
                end
                StStop: begin
                    if (en)            state_q <= StStart;
                    else if (all_zero) state_q <= StOff;
                end
                default: state_q <= StOff;
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign duty_o[g*DUTY_W +: DUTY_W] = cur_q[g];
    end

    assign wr_ready = wr_ready_q;
    assign pwm_en   = pwm_en_q;
    assign busy     = busy_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl (N_CH=4, DUTY_W=8, STEP=16, RAMP_DIV=2).
// Expected duty sequences differ between the ramped and direct builds (PWM_RAMP_EN).
module tb_pwm_ramp_ctrl;

    localparam int unsigned N_CH     = 4;
    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned STEP     = 16;
    localparam int unsigned RAMP_DIV = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   en;
    logic                   period_end;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [1:0]             wr_ch;
    logic [DUTY_W-1:0]      wr_duty;
    logic [N_CH*DUTY_W-1:0] duty_o;
    logic                   pwm_en;
    logic                   busy;
    logic [1:0]             state_o;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned exp_q[$];

    pwm_ramp_ctrl #(
        .N_CH     (N_CH),
        .DUTY_W   (DUTY_W),
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .period_end (period_end),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_duty    (wr_duty),
        .duty_o     (duty_o),
        .pwm_en     (pwm_en),
        .busy       (busy),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] duty_of(input int ch);
        return 32'(duty_o[ch*DUTY_W +: DUTY_W]);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle period_end pulse; returns at the negedge after the sampling edge.
    task automatic pulse();
        period_end = 1'b1;
        @(negedge clk);
        period_end = 1'b0;
    endtask

    task automatic pulse_wr(input logic [1:0] ch, input logic [DUTY_W-1:0] d);
        period_end = 1'b1;
        wr_valid   = 1'b1;
        wr_ch      = ch;
        wr_duty    = d;
        @(negedge clk);
        period_end = 1'b0;
        wr_valid   = 1'b0;
    endtask

    task automatic write(input logic [1:0] ch, input logic [DUTY_W-1:0] d);
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_duty  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Pulse period_end once per entry of exp_q and check one channel after each.
    task automatic run_seq(input string tag, input int ch);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k != 0) idle(9);
            pulse();
            check_eq($sformatf("%s[%0d]", tag, k), duty_of(ch), 32'(exp_q[k]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        period_end = 1'b0;
        wr_valid   = 1'b0;
        wr_ch      = '0;
        wr_duty    = '0;

        // Reset state.
        idle(3);
        check_eq("rst_duty", 32'(duty_o), 0);
        check_eq("rst_pwm_en", 32'(pwm_en), 0);
        check_eq("rst_state", 32'(state_o), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_wr_ready", 32'(wr_ready), 0);
        rst_n = 1'b1;
        check_eq("rel_wr_ready_0", 32'(wr_ready), 0);
        @(negedge clk);
        check_eq("rel_wr_ready_1", 32'(wr_ready), 1);
        idle(3);
        check_eq("idle_state", 32'(state_o), 0);
        check_eq("idle_pwm_en", 32'(pwm_en), 0);

        // Soft-start channel 0 toward 64.
        write(2'd0, 8'd64);
        check_eq("off_busy", 32'(busy), 0);
        en = 1'b1;
        @(negedge clk);
        check_eq("start_state", 32'(state_o), 1);
        check_eq("start_pwm_en_lag", 32'(pwm_en), 0);
        @(negedge clk);
        check_eq("start_pwm_en", 32'(pwm_en), 1);
        check_eq("start_busy", 32'(busy), 1);
        idle(7);
`ifdef PWM_RAMP_EN
        exp_q = '{0, 16, 16, 32, 32, 48, 48, 64};
`else
        exp_q = '{64};
`endif
        run_seq("ss_ch0", 0);
        check_eq("ss_state_pre", 32'(state_o), 1);
        check_eq("ss_busy_pre", 32'(busy), 1);
        @(negedge clk);
        check_eq("ss_state_run", 32'(state_o), 2);
        check_eq("ss_busy_done", 32'(busy), 0);
        idle(8);

        // New target in RUN saturates at 40.
        write(2'd1, 8'd40);
        idle(8);
`ifdef PWM_RAMP_EN
        exp_q = '{0, 16, 16, 32, 32, 40};
`else
        exp_q = '{40};
`endif
        run_seq("run_ch1", 1);
        check_eq("run_state", 32'(state_o), 2);
        check_eq("run_ch0_hold", duty_of(0), 64);
        check_eq("run_busy_pre", 32'(busy), 1);
        @(negedge clk);
        check_eq("run_busy_done", 32'(busy), 0);
        idle(8);

        // Soft-stop.
        en = 1'b0;
        @(negedge clk);
        check_eq("stop_state", 32'(state_o), 3);
        idle(8);
`ifdef PWM_RAMP_EN
        exp_q = '{64, 48, 48, 32, 32, 16, 16, 0};
`else
        exp_q = '{0};
`endif
        run_seq("sp_ch0", 0);
        check_eq("sp_ch1", duty_of(1), 0);
        check_eq("sp_state_pre", 32'(state_o), 3);
        @(negedge clk);
        check_eq("sp_state_off", 32'(state_o), 0);
        check_eq("sp_pwm_en_lag", 32'(pwm_en), 1);
        @(negedge clk);
        check_eq("sp_pwm_en_off", 32'(pwm_en), 0);
        idle(3);

        // Write coinciding with a tick: the tick uses the old ch2 target of 0.
        en = 1'b1;
        idle(2);
`ifdef PWM_RAMP_EN
        pulse();
        check_eq("wt_ch0_notick", duty_of(0), 0);
        idle(9);
        pulse_wr(2'd2, 8'd200);
        check_eq("wt_ch2_old", duty_of(2), 0);
        check_eq("wt_ch0_tick", duty_of(0), 16);
        idle(9);
        pulse();
        check_eq("wt_ch2_hold", duty_of(2), 0);
        idle(9);
        pulse();
        check_eq("wt_ch2_new", duty_of(2), 16);
        check_eq("wt_ch0_mid", duty_of(0), 32);
`else
        pulse_wr(2'd2, 8'd200);
        check_eq("wt_ch2_old", duty_of(2), 0);
        check_eq("wt_ch0_tick", duty_of(0), 64);
        idle(9);
        pulse();
        check_eq("wt_ch2_new", duty_of(2), 200);
`endif

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_duty", 32'(duty_o), 0);
        check_eq("ar_pwm_en", 32'(pwm_en), 0);
        check_eq("ar_state", 32'(state_o), 0);
        check_eq("ar_busy", 32'(busy), 0);
        check_eq("ar_wr_ready", 32'(wr_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ar_rel_state", 32'(state_o), 1);
        check_eq("ar_rel_wr_ready", 32'(wr_ready), 1);
        @(negedge clk);
        // Cleared targets mean START is already complete.
        check_eq("ar_tgt_clear_state", 32'(state_o), 2);
        check_eq("ar_tgt_clear_duty", 32'(duty_o), 0);
        check_eq("ar_tgt_clear_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
